// File: rtl/axi_request_arbiter.sv
// axi_request_arbiter
// Shares one AXI4 manager port among Requesters request/response clients,
// one single-beat 32-bit transaction at a time, with round-robin grants.
// The requester index is used as the AXI ID and checked on the response.
// Optional feature macro: RENODE_AXI_ARBITER_TIMEOUT_EN compiles in a
// grant-to-response cycle timeout that aborts stalled transactions.
module axi_request_arbiter #(
   parameter int Requesters         = 4,
   parameter int AddressWidth       = 20,
   parameter int TransactionIdWidth = 8,
   parameter int TimeoutCycles      = 100
) (
   input  logic                               clk,
   input  logic                               reset,
   // client side
   input  logic [Requesters-1:0]              req_valid,
   output logic [Requesters-1:0]              req_ready,
   input  logic [Requesters-1:0]              req_write,
   input  logic [Requesters*AddressWidth-1:0] req_addr,
   input  logic [Requesters*32-1:0]           req_wdata,
   output logic [Requesters-1:0]              rsp_valid,
   output logic [31:0]                        rsp_rdata,
   output logic                               rsp_error,
   // AW channel
   output logic [TransactionIdWidth-1:0]      awid,
   output logic [AddressWidth-1:0]            awaddr,
   output logic [7:0]                         awlen,
   output logic [2:0]                         awsize,
   output logic [1:0]                         awburst,
   output logic                               awlock,
   output logic [3:0]                         awcache,
   output logic [2:0]                         awprot,
   output logic                               awvalid,
   input  logic                               awready,
   // W channel
   output logic [31:0]                        wdata,
   output logic [3:0]                         wstrb,
   output logic                               wlast,
   output logic                               wvalid,
   input  logic                               wready,
   // B channel
   input  logic [TransactionIdWidth-1:0]      bid,
   input  logic [1:0]                         bresp,
   input  logic                               bvalid,
   output logic                               bready,
   // AR channel
   output logic [TransactionIdWidth-1:0]      arid,
   output logic [AddressWidth-1:0]            araddr,
   output logic [7:0]                         arlen,
   output logic [2:0]                         arsize,
   output logic [1:0]                         arburst,
   output logic                               arlock,
   output logic [3:0]                         arcache,
   output logic [2:0]                         arprot,
   output logic                               arvalid,
   input  logic                               arready,
   // R channel
   input  logic [TransactionIdWidth-1:0]      rid,
   input  logic [31:0]                        rdata,
   input  logic [1:0]                         rresp,
   input  logic                               rlast,
   input  logic                               rvalid,
   output logic                               rready
);

   localparam int IdxW = $clog2(Requesters);

   if (Requesters < 2 || TransactionIdWidth < IdxW || TimeoutCycles < 2) begin : g_param_check
      $error("axi_request_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

   state_e                  state_q, state_d;
   logic [IdxW-1:0]         last_grant_q, last_grant_d;
   logic [IdxW-1:0]         grant_q, grant_d;
   logic                    write_q, write_d;
   logic [AddressWidth-1:0] addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    error_q, error_d;

   logic                    pick_valid;
   logic [IdxW-1:0]         pick_idx;
   logic                    tmo_hit;
   logic                    aw_ok, w_ok;
   logic [TransactionIdWidth-1:0] gid;

`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutCycles + 1);
   logic [TmoW-1:0]         cnt_q, cnt_d;
`endif

   assign gid = TransactionIdWidth'(grant_q);

   // Round-robin search starting just after the previous grant
   always_comb begin : arb
      int cand;
      cand       = 0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= Requesters; i++) begin
         cand = int'(last_grant_q) + i;
         if (cand >= Requesters) cand = cand - Requesters;
         if (!pick_valid && req_valid[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = IdxW'(cand);
         end
      end
   end

   // Next-state logic and handshake outputs for the transaction FSM
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      rdata_d      = rdata_q;
      error_d      = error_q;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      arvalid      = 1'b0;
      bready       = 1'b0;
      rready       = 1'b0;
      req_ready    = '0;
      aw_ok        = 1'b0;
      w_ok         = 1'b0;
`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
      cnt_d        = cnt_q;
      tmo_hit      = 1'b0;
      if (state_q == ADDR || state_q == RESP) begin
         cnt_d   = cnt_q + TmoW'(1);
         // the edge that would bring the count to TimeoutCycles aborts
         tmo_hit = (cnt_q >= TmoW'(TimeoutCycles - 1));
      end
`else
      tmo_hit      = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            // sink stray or late responses
            bready = 1'b1;
            rready = 1'b1;
            if (pick_valid) begin
               req_ready    = Requesters'(1) << pick_idx;
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               write_d      = req_write[pick_idx];
               addr_d       = req_addr[int'(pick_idx)*AddressWidth +: AddressWidth];
               wdata_d      = req_wdata[int'(pick_idx)*32 +: 32];
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               rdata_d      = '0;
               error_d      = 1'b0;
`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
               cnt_d        = '0;
`endif
               state_d      = ADDR;
            end
         end
         ADDR: begin
            if (write_q) begin
               awvalid   = !aw_done_q;
               wvalid    = !w_done_q;
               aw_ok     = aw_done_q || awready;
               w_ok      = w_done_q || wready;
               aw_done_d = aw_ok;
               w_done_d  = w_ok;
               if (aw_ok && w_ok) begin
                  state_d = RESP;
               end else if (tmo_hit) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  rdata_d = '0;
               end
            end else begin
               arvalid = 1'b1;
               if (arready) begin
                  state_d = RESP;
               end else if (tmo_hit) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         RESP: begin
            // a response arriving on the timeout edge takes priority
            if (write_q) begin
               bready = 1'b1;
               if (bvalid) begin
                  error_d = (bid != gid) || (bresp == 2'b10) || (bresp == 2'b11);
                  rdata_d = '0;
                  state_d = DONE;
               end else if (tmo_hit) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  rdata_d = '0;
               end
            end else begin
               rready = 1'b1;
               if (rvalid && rlast) begin
                  error_d = (rid != gid) || (rresp == 2'b10) || (rresp == 2'b11);
                  rdata_d = error_d ? 32'h0 : rdata;
                  state_d = DONE;
               end else if (tmo_hit) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and transaction registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= IdxW'(Requesters - 1);
         grant_q      <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         rdata_q      <= '0;
         error_q      <= 1'b0;
`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         rdata_q      <= rdata_d;
         error_q      <= error_d;
`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   // Response pulse to the owning client and fixed AXI fields
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      rsp_error = 1'b0;
      if (state_q == DONE) begin
         rsp_valid = Requesters'(1) << grant_q;
         rsp_rdata = rdata_q;
         rsp_error = error_q;
      end
      awid    = gid;
      awaddr  = addr_q;
      awlen   = 8'd0;
      awsize  = 3'b010;
      awburst = 2'b00;
      awlock  = 1'b0;
      awcache = 4'd0;
      awprot  = 3'd0;
      wdata   = wdata_q;
      wstrb   = 4'hF;
      wlast   = 1'b1;
      arid    = gid;
      araddr  = addr_q;
      arlen   = 8'd0;
      arsize  = 3'b010;
      arburst = 2'b00;
      arlock  = 1'b0;
      arcache = 4'd0;
      arprot  = 3'd0;
   end

endmodule

// File: tb/tb_axi_request_arbiter.sv
// Directed testbench for axi_request_arbiter (4 clients, 20-bit address,
// 8-bit ID). The timeout scenario runs only when
// RENODE_AXI_ARBITER_TIMEOUT_EN is defined.
module tb_axi_request_arbiter;

   localparam int R  = 4;
   localparam int AW = 20;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [R-1:0]  req_valid, req_ready, req_write, rsp_valid;
   logic [R*AW-1:0] req_addr;
   logic [R*32-1:0] req_wdata;
   logic [31:0]   rsp_rdata;
   logic          rsp_error;
   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize, awprot, arprot;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awlock, arlock;
   logic [3:0]    awcache, arcache, wstrb;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [31:0]   wdata, rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi_request_arbiter #(
      .Requesters(R), .AddressWidth(AW), .TransactionIdWidth(IW), .TimeoutCycles(100)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bid = '0; bresp = 2'b00; bvalid = 1'b0;
      rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++;
      if (rsp_valid !== 4'b0000 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h, expected 0/0/0", rsp_valid, rsp_error, rsp_rdata);
      end
      n_tests++;
      if ({awvalid, wvalid, arvalid} !== 3'b000 || {bready, rready} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_hs: got aw/w/ar valid=%b b/r ready=%b, expected 000/11", {awvalid, wvalid, arvalid}, {bready, rready});
      end
      n_tests++;
      if (awaddr !== 20'h0 || awid !== 8'h0 || wdata !== 32'h0 || req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_data: got awaddr=%h awid=%h wdata=%h req_ready=%b, expected zeros", awaddr, awid, wdata, req_ready);
      end
      // all requesting: client 0 must win first (combinational, withdrawn before the edge)
      req_valid = 4'b1111;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_read_basic();
      req_valid = 4'b0010;
      req_write = 4'b0000;
      req_addr[1*AW +: AW] = 20'h00040;
      arready = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL rd_accept: got req_ready=%b expected 0010", req_ready);
      end
      tick(); // cycle 1
      req_valid = 4'b0000;
      #1;
      n_tests++;
      if (arvalid !== 1'b1 || araddr !== 20'h00040 || arid !== 8'd1 || awvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_ar: got arvalid=%b araddr=%h arid=%h awvalid=%b, expected 1/00040/01/0", arvalid, araddr, arid, awvalid);
      end
      n_tests++;
      if (arlen !== 8'd0 || arsize !== 3'b010 || arburst !== 2'b00 || arcache !== 4'd0 || arprot !== 3'd0 || arlock !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_fixed: got len=%h size=%b burst=%b cache=%h prot=%h lock=%b", arlen, arsize, arburst, arcache, arprot, arlock);
      end
      tick(); // cycle 2
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'hDEADBEEF; rid = 8'd1; rresp = 2'b00; rlast = 1'b1;
      #1;
      n_tests++;
      if (rready !== 1'b1 || arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_resp_state: got rready=%b arvalid=%b expected 1/0", rready, arvalid);
      end
      tick(); // cycle 3
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hDEADBEEF || rsp_error !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_rsp: got valid=%b rdata=%h err=%b, expected 0010/deadbeef/0", rsp_valid, rsp_rdata, rsp_error);
      end
      tick(); // cycle 4
      n_tests++;
      if (rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL rd_rsp_pulse: got valid=%b expected 0000", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] order [5];
      logic [1:0] g;
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req_valid = 4'b1111;
      req_write = 4'b1111;
      for (int i = 0; i < R; i++) begin
         req_addr[i*AW +: AW] = 20'h01000 + 20'(i * 16'h0110);
         req_wdata[i*32 +: 32] = 32'hA5A50000 + 32'(i);
      end
      awready = 1'b1;
      wready  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         g = order[k];
         #1;
         n_tests++;
         if (req_ready !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got req_ready=%b expected client %0d", k, req_ready, g);
         end
         tick(); // ADDR
         n_tests++;
         if (awvalid !== 1'b1 || wvalid !== 1'b1 || awid !== 8'(g) ||
             awaddr !== 20'h01000 + 20'(g * 16'h0110) || wdata !== 32'hA5A50000 + 32'(g) ||
             wstrb !== 4'hF || wlast !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_aw%0d: got awv=%b wv=%b awid=%h awaddr=%h wdata=%h wstrb=%h wlast=%b for client %0d",
                     k, awvalid, wvalid, awid, awaddr, wdata, wstrb, wlast, g);
         end
         tick(); // RESP
         bvalid = 1'b1; bid = 8'(g); bresp = 2'b00;
         #1;
         n_tests++;
         if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_resp%0d: got bready=%b awv=%b wv=%b expected 1/0/0", k, bready, awvalid, wvalid);
         end
         tick(); // DONE
         bvalid = 1'b0;
         #1;
         n_tests++;
         if (rsp_valid !== (4'b0001 << g) || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rr_rsp%0d: got valid=%b err=%b rdata=%h expected client %0d ok", k, rsp_valid, rsp_error, rsp_rdata, g);
         end
         tick(); // IDLE
      end
      req_valid = 4'b0000;
      awready = 1'b0;
      wready  = 1'b0;
   endtask

   task automatic test_write_late_aw();
      req_valid = 4'b0100;
      req_write = 4'b0100;
      req_addr[2*AW +: AW] = 20'h00ABC;
      req_wdata[2*32 +: 32] = 32'h12345678;
      awready = 1'b0;
      wready  = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL wl_accept: got req_ready=%b expected 0100", req_ready);
      end
      tick(); // cycle 1: ADDR, W handshake
      req_valid = 4'b0000;
      #1;
      n_tests++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL wl_c1: got awv=%b wv=%b expected 1/1", awvalid, wvalid);
      end
      tick(); // cycle 2
      n_tests++;
      if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0) begin
         n_fail++;
         $display("FAIL wl_c2: got awv=%b wv=%b bready=%b expected 1/0/0", awvalid, wvalid, bready);
      end
      tick(); // cycle 3
      n_tests++;
      if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0 || awaddr !== 20'h00ABC) begin
         n_fail++;
         $display("FAIL wl_c3: got awv=%b wv=%b bready=%b awaddr=%h expected 1/0/0/00abc", awvalid, wvalid, bready, awaddr);
      end
      tick(); // cycle 4: AW handshake
      awready = 1'b1;
      #1;
      n_tests++;
      if (awvalid !== 1'b1 || awaddr !== 20'h00ABC || awid !== 8'd2 || bready !== 1'b0) begin
         n_fail++;
         $display("FAIL wl_c4: got awv=%b awaddr=%h awid=%h bready=%b expected 1/00abc/02/0", awvalid, awaddr, awid, bready);
      end
      tick(); // cycle 5: RESP
      awready = 1'b0;
      bvalid = 1'b1; bid = 8'd2; bresp = 2'b01;
      #1;
      n_tests++;
      if (awvalid !== 1'b0 || bready !== 1'b1) begin
         n_fail++;
         $display("FAIL wl_resp: got awv=%b bready=%b expected 0/1", awvalid, bready);
      end
      tick(); // cycle 6: DONE
      bvalid = 1'b0;
      wready = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 4'b0100 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL wl_rsp: got valid=%b err=%b rdata=%h expected 0100/0/0", rsp_valid, rsp_error, rsp_rdata);
      end
      tick(); // IDLE
   endtask

   task automatic test_read_errors();
      logic [7:0]  v_id   [3];
      logic [1:0]  v_resp [3];
      logic [31:0] v_data [3];
      logic        e_err  [3];
      logic [31:0] e_data [3];
      v_id   = '{8'd2, 8'd5, 8'd2};
      v_resp = '{2'b10, 2'b00, 2'b11};
      v_data = '{32'h000055AA, 32'h11112222, 32'h33334444};
      e_err  = '{1'b1, 1'b1, 1'b1};
      e_data = '{32'h0, 32'h0, 32'h0};
      for (int k = 0; k < 4; k++) begin
         req_valid = 4'b0100;
         req_write = 4'b0000;
         req_addr[2*AW +: AW] = 20'h00200 + 20'(k);
         arready = 1'b1;
         tick(); // ADDR
         req_valid = 4'b0000;
         tick(); // RESP
         arready = 1'b0;
         rvalid = 1'b1; rlast = 1'b1;
         if (k < 3) begin
            rid = v_id[k]; rresp = v_resp[k]; rdata = v_data[k];
         end else begin
            rid = 8'd2; rresp = 2'b01; rdata = 32'h0BADF00D;
         end
         tick(); // DONE
         rvalid = 1'b0; rlast = 1'b0;
         #1;
         n_tests++;
         if (k < 3) begin
            if (rsp_valid !== 4'b0100 || rsp_error !== e_err[k] || rsp_rdata !== e_data[k]) begin
               n_fail++;
               $display("FAIL rderr%0d: got valid=%b err=%b rdata=%h expected 0100/%b/%h", k, rsp_valid, rsp_error, rsp_rdata, e_err[k], e_data[k]);
            end
         end else begin
            if (rsp_valid !== 4'b0100 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin
               n_fail++;
               $display("FAIL rdok_exokay: got valid=%b err=%b rdata=%h expected 0100/0/0badf00d", rsp_valid, rsp_error, rsp_rdata);
            end
         end
         tick(); // IDLE
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b1000;
      req_write = 4'b0000;
      req_addr[3*AW +: AW] = 20'h00300;
      arready = 1'b1;
      tick(); // ADDR
      req_valid = 4'b0000;
      #1;
      n_tests++;
      if (arvalid !== 1'b1 || arid !== 8'd3) begin
         n_fail++;
         $display("FAIL rm_addr: got arvalid=%b arid=%h expected 1/03", arvalid, arid);
      end
      tick(); // RESP: reset instead of a response
      arready = 1'b0;
      reset = 1'b1;
      tick(); // IDLE after reset
      reset = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 4'b0000 || {awvalid, wvalid, arvalid} !== 3'b000 || {bready, rready} !== 2'b11) begin
         n_fail++;
         $display("FAIL rm_idle: got rsp_valid=%b valids=%b readies=%b expected 0000/000/11", rsp_valid, {awvalid, wvalid, arvalid}, {bready, rready});
      end
      tick();
      n_tests++;
      if (rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL rm_no_rsp: got rsp_valid=%b expected 0000", rsp_valid);
      end
      req_valid = 4'b1111;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rm_grant0: got req_ready=%b expected 0001", req_ready);
      end
      req_valid = 4'b0000;
   endtask

`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      req_valid = 4'b0001;
      req_write = 4'b0001;
      req_addr[0 +: AW] = 20'h00400;
      awready = 1'b1;
      wready  = 1'b1;
      tick(); // cycle 1
      req_valid = 4'b0000;
      n = 1;
      while (rsp_valid === 4'b0000 && n < 200) begin
         tick();
         n++;
      end
      awready = 1'b0;
      wready  = 1'b0;
      n_tests++;
      if (n != 101) begin
         n_fail++;
         $display("FAIL to_latency: got pulse at cycle %0d expected 101", n);
      end
      n_tests++;
      if (rsp_valid !== 4'b0001 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0 ||
          {awvalid, wvalid, arvalid, bready, rready} !== 5'b00000) begin
         n_fail++;
         $display("FAIL to_abort: got valid=%b err=%b rdata=%h handshakes=%b expected 0001/1/0/00000",
                  rsp_valid, rsp_error, rsp_rdata, {awvalid, wvalid, arvalid, bready, rready});
      end
      tick(); // IDLE: late response arrives
      bvalid = 1'b1; bid = 8'd0; bresp = 2'b00;
      #1;
      n_tests++;
      if (bready !== 1'b1) begin
         n_fail++;
         $display("FAIL to_sink: got bready=%b expected 1", bready);
      end
      tick();
      bvalid = 1'b0;
      n_tests++;
      if (rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_late: got rsp_valid=%b expected 0000", rsp_valid);
      end
      tick();
      n_tests++;
      if (rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_late2: got rsp_valid=%b expected 0000", rsp_valid);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_read_basic();
      test_round_robin();
      test_write_late_aw();
      test_read_errors();
      test_reset_mid();
`ifdef RENODE_AXI_ARBITER_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_request_arbiter.md
# axi_request_arbiter

- Shares one AXI4 manager port among `Requesters` simple request/response clients, one single-beat 32-bit transaction at a time.
- Grants are round-robin. Each transaction is tagged with the requester index as its AXI ID; the response ID and response code are checked.
- Stalled transactions are aborted by a cycle timeout.
- Sits between Renode-side bus bridges or local masters and the AXI subordinate under test.

## Interface
- `Requesters`, 4: number of clients, 2..16.
- `AddressWidth`, 20: AXI address width.
- `TransactionIdWidth`, 8: AXI ID width; must be ≥ `$clog2(Requesters)`.
- `TimeoutCycles`, 100: cycles allowed from grant to response before abort; ≥ 2.
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `Requesters`: per-client request pending.
- `req_ready` out `Requesters`: one-hot acceptance; request is taken when valid & ready.
- `req_write` in `Requesters`: 1 = write, 0 = read.
- `req_addr` in `Requesters*AddressWidth`: packed addresses; client i occupies slice i.
- `req_wdata` in `Requesters*32`: packed write data.
- `rsp_valid` out `Requesters`: one-cycle response pulse to the owning client; no backpressure.
- `rsp_rdata` out 32: read data, shared by all clients; 0 for writes and errors.
- `rsp_error` out 1: response error flag, shared by all clients.
- AW channel, out: `awid` (`TransactionIdWidth`), `awaddr` (`AddressWidth`), `awlen` 8, `awsize` 3, `awburst` 2, `awlock` 1, `awcache` 4, `awprot` 3, `awvalid` 1; in: `awready`.
- W channel, out: `wdata` 32, `wstrb` 4, `wlast` 1, `wvalid` 1; in: `wready`.
- B channel, in: `bid`, `bresp` 2, `bvalid`; out: `bready`.
- AR channel, out: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arvalid`; in: `arready`.
- R channel, in: `rid`, `rdata` 32, `rresp` 2, `rlast`, `rvalid`; out: `rready`.

## Operation
- States: IDLE, ADDR, RESP, DONE.
- **IDLE**
  - Arbitration is combinational: search starts at `last_grant+1` modulo `Requesters`; the first client with `req_valid` set is chosen.
  - The chosen client's `req_ready` is 1 in this same cycle.
  - On the accept edge: latch the index, write flag, address and data; update `last_grant`; clear the timeout counter; go to ADDR.
  - `bready` and `rready` are 1 in IDLE, so stray or late responses are sunk and discarded.
- **ADDR, write**
  - `awvalid` and `wvalid` are both 1. Each drops independently after its own handshake.
  - Go to RESP when both handshakes are complete; they may occur in the same or different cycles.
- **ADDR, read**
  - `arvalid` is 1 until `arready`; then go to RESP.
- **Fixed fields**
  - `*len` = 0, `*size` = 3'b010, `*burst` = 0, `*lock` = 0, `*cache` = 0, `*prot` = 0.
  - `wstrb` = 4'hF, `wlast` = 1.
  - `awid`/`arid` = granted index, zero-extended.
- **RESP**
  - `bready` (write) or `rready` (read) is 1.
  - On `bvalid`, or on `rvalid && rlast`: capture the response and go to DONE.
  - Error if the ID differs from the granted index, or if `resp` is 2'b10 or 2'b11. `resp` 2'b00 and 2'b01 are OK.
- **DONE**
  - Pulse `rsp_valid[grant]` for one cycle with `rsp_rdata` and `rsp_error`; return to IDLE.
- **Timeout**
  - The counter increments every cycle in ADDR and RESP.
  - When it reaches `TimeoutCycles`: clear all VALID and READY outputs, go to DONE with `rsp_error` = 1 and `rsp_rdata` = 0.
  - This is a deliberate protocol abort; any late response is sunk in IDLE.
- **Reset**
  - A reset mid-transaction abandons it. No `rsp_valid` is emitted for it.

## Timing
- **Reset values:**
  - state = IDLE; `last_grant` = `Requesters-1`, so client 0 wins first.
  - All `*valid`, `rsp_valid` and `rsp_error` = 0; `rsp_rdata` = 0.
  - `bready` = `rready` = 1 (IDLE value); `req_ready` follows the IDLE arbitration.
  - Address, ID and data outputs = 0.
- **Minimum latency** (read or write, subordinate ready immediately):
  - cycle 0: accept;
  - cycle 1: `arvalid`/`awvalid`+`wvalid` high, handshake;
  - cycle 2: RESP, response handshake;
  - cycle 3: `rsp_valid`.
- **Throughput:** the next accept happens at the earliest in the cycle after DONE. There is at most one outstanding transaction.
- **Handshakes:** VALID outputs never drop before READY, except on timeout. Address and data are held stable while VALID is high.
- **Timeout edge:** if the response handshake and counter == `TimeoutCycles` occur in the same cycle, the response wins.

## Configuration
- `RENODE_AXI_ARBITER_TIMEOUT_EN`
  - Defined: the timeout counter and abort path are compiled in, as described above.
  - Undefined: no counter; ADDR and RESP wait indefinitely; `TimeoutCycles` is ignored.

## Test plan
- Client 1 reads 0x00040 and the subordinate returns 0xDEADBEEF, `rid`=1, OKAY → `rsp_valid`=4'b0010 at cycle 3, `rsp_rdata`=0xDEADBEEF, `rsp_error`=0.
- All 4 clients request writes continuously from reset → grant order 0,1,2,3,0; `awid`/`awaddr`/`wdata` match each client.
- Write with `awready` 3 cycles late and `wready` immediate → `wvalid` drops after 1 cycle; RESP is entered only after the AW handshake; OKAY → `rsp_error`=0.
- Read answered with `rresp`=2'b10 or `rid`=5 (grant 2) → `rsp_error`=1 in both cases.
- Subordinate never answers (macro defined, `TimeoutCycles`=100) → error pulse 101 cycles after accept, all VALIDs 0; a late `bvalid` is absorbed in IDLE with no `rsp_valid`.
- `reset` asserted in RESP → next cycle: IDLE, all VALIDs 0, no `rsp_valid`; client 0 is granted first afterwards.
